xor_popcount_acc: RTL and testbench

XOR_POPCOUNT_ACC -- requirements
Module: xor_popcount_acc

---
 rtl/xor_popcount_acc.sv | 142 ++++++++++++++
 tb/tb_xor_popcount_acc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/xor_popcount_acc.sv
// Binary-neuron accumulator: sums popcount(x^w) beats, then reports count and activation.
// Define POPACC_SAT_EN for a saturating accumulator with out_sat; otherwise it wraps and out_sat is 0.
module xor_popcount_acc #(
  parameter int LANES     = 2,
  parameter int ACC_W     = 8,
  parameter int MAX_BEATS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] thresh,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_bit,
  output logic             out_forced,
  output logic             out_sat,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // in_ready depends on state only, out_valid is the DONE state, results hold until out_ready.

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam int POP_W = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_thresh;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [ACC_W-1:0] r_out_count;
  logic             r_out_bit;
  logic             r_out_forced;
  logic             r_out_sat;
  logic [POP_W-1:0] w_pop;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_sat_next;
  logic             w_accept;
  logic             w_cap;
  logic             w_final;
  logic             w_start;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + POP_W'(in_op[i]);
    end
  end

`ifdef POPACC_SAT_EN
  logic [ACC_W:0] w_sum;
  logic           r_sat;

  assign w_sum      = {1'b0, r_acc} + (ACC_W + 1)'(w_pop);
  assign w_acc_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  // Sticky for the neuron: any overflowing addition marks the result.
  assign w_sat_next = r_sat | w_sum[ACC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (w_start) begin
      r_sat <= 1'b0;
    end else if (w_accept) begin
      r_sat <= w_sat_next;
    end
  end

  assign out_sat = r_out_sat;
`else
  assign w_acc_next = r_acc + ACC_W'(w_pop);
  assign w_sat_next = 1'b0;
  assign out_sat    = 1'b0;
`endif

  assign in_ready  = (r_state == S_ACC);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

  assign w_start  = (r_state == S_IDLE) && start;
  assign w_accept = in_valid && in_ready;
  assign w_cap    = (r_beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign w_final  = w_accept && (in_last || w_cap);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ACC;
      S_ACC:   if (w_final) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_beat_cnt   <= '0;
      r_thresh     <= '0;
      r_out_count  <= '0;
      r_out_bit    <= 1'b0;
      r_out_forced <= 1'b0;
      r_out_sat    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_acc      <= '0;
        r_beat_cnt <= '0;
        r_thresh   <= thresh;
      end else if (w_accept) begin
        r_acc      <= w_acc_next;
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      // Result registers load only on the final beat, so they retain the last result elsewhere.
      if (w_final) begin
        r_out_count  <= w_acc_next;
        r_out_bit    <= (w_acc_next < r_thresh);
        r_out_forced <= w_cap && !in_last;
        r_out_sat    <= w_sat_next;
      end
    end
  end

  assign out_count  = r_out_count;
  assign out_bit    = r_out_bit;
  assign out_forced = r_out_forced;

endmodule

// File: tb/tb_xor_popcount_acc.sv
// Bench for xor_popcount_acc: two instances (ACC_W=8 and ACC_W=3, both MAX_BEATS=4) share stimulus.
// Honours POPACC_SAT_EN when computing the expected ACC_W=3 results.
module tb_xor_popcount_acc;
  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] thresh;
  logic       in_valid;
  logic [1:0] in_op;
  logic       in_last;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_bit, a_out_forced, a_out_sat, a_busy;
  logic [7:0] a_out_count;
  logic [1:0] a_dbg;
  logic       b_in_ready, b_out_valid, b_out_bit, b_out_forced, b_out_sat, b_busy;
  logic [2:0] b_out_count;
  logic [1:0] b_dbg;

  int checks   = 0;
  int failures = 0;

  logic [16:0] exp_q[$];
  logic [16:0] prev_res;
  logic [1:0]  beat_op[MAXB];
  logic        beat_last[MAXB];

  // clock / reset
  always #5 clk = ~clk;

  xor_popcount_acc #(.LANES(2), .ACC_W(8), .MAX_BEATS(MAXB)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .thresh(thresh),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_op(in_op), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_count(a_out_count),
    .out_bit(a_out_bit), .out_forced(a_out_forced), .out_sat(a_out_sat),
    .busy(a_busy), .dbg_state(a_dbg)
  );

  xor_popcount_acc #(.LANES(2), .ACC_W(3), .MAX_BEATS(MAXB)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .thresh(thresh[2:0]),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_op(in_op), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_count(b_out_count),
    .out_bit(b_out_bit), .out_forced(b_out_forced), .out_sat(b_out_sat),
    .busy(b_busy), .dbg_state(b_dbg)
  );

  function automatic logic [16:0] obs_res();
    return {a_out_sat, a_out_forced, a_out_bit, a_out_count,
            b_out_sat, b_out_forced, b_out_bit, b_out_count};
  endfunction

  function automatic logic [5:0] obs_ctl();
    return {a_busy, a_in_ready, a_out_valid, b_busy, b_in_ready, b_out_valid};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: total mismatches over the beats up to the first in_last or the MAXB-th beat.
  function automatic logic [16:0] model(input int th);
    int   sum = 0;
    logic forced = 1'b0;
    int   a_cnt, b_cnt;
    logic a_bit, b_bit, b_sat;
    for (int k = 0; k < MAXB; k++) begin
      sum += $countones(beat_op[k]);
      if (beat_last[k]) break;
      if (k == MAXB - 1) forced = 1'b1;
    end
    a_cnt = sum % 256;
    a_bit = (a_cnt < th);
`ifdef POPACC_SAT_EN
    b_cnt = (sum > 7) ? 7 : sum;
    b_sat = (sum > 7);
`else
    b_cnt = sum % 8;
    b_sat = 1'b0;
`endif
    b_bit = (b_cnt < (th % 8));
    return {1'b0, forced, a_bit, 8'(a_cnt), b_sat, forced, b_bit, 3'(b_cnt)};
  endfunction

  // driver tasks
  task automatic load(input logic [7:0] ops, input logic [3:0] lasts);
    for (int k = 0; k < MAXB; k++) begin
      beat_op[k]   = ops[2*k +: 2];
      beat_last[k] = lasts[k];
    end
  endtask

  task automatic do_start(input int th);
    start  = 1'b1;
    thresh = 8'(th);
    @(negedge clk);
    start  = 1'b0;
    thresh = 8'($urandom_range(0, 255));
    chk("acc_ctl", 32'(obs_ctl()), 32'(6'b110110));
  endtask

  task automatic send_beats(input bit noise);
    for (int i = 0; i < MAXB; i++) begin
      int gaps;
      gaps = noise ? $urandom_range(1, 3) : 0;
      repeat (gaps) begin
        in_valid = 1'b0;
        in_op    = 2'($urandom);
        in_last  = 1'($urandom);
        start    = noise;
        thresh   = 8'($urandom_range(0, 255));
        @(negedge clk);
        start = 1'b0;
        chk("gap_ctl", 32'(obs_ctl()), 32'(6'b110110));
        chk("gap_hold", 32'(obs_res()), 32'(prev_res));
      end
      in_valid = 1'b1;
      in_op    = beat_op[i];
      in_last  = beat_last[i];
      start    = noise && ($urandom_range(0, 1) == 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      start    = 1'b0;
      if (beat_last[i]) break;
    end
  endtask

  task automatic finish_result(input int hold, input bit noise);
    chk("done_ctl", 32'(obs_ctl()), 32'(6'b101101));
    chk("result", 32'(obs_res()), 32'(exp_q[0]));
    repeat (hold) begin
      out_ready = 1'b0;
      start     = noise;
      @(negedge clk);
      start = 1'b0;
      chk("hold_ctl", 32'(obs_ctl()), 32'(6'b101101));
      chk("hold_result", 32'(obs_res()), 32'(exp_q[0]));
    end
    out_ready = 1'b1;
    start     = noise;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    prev_res  = exp_q.pop_front();
    chk("idle_ctl", 32'(obs_ctl()), 32'(6'b000000));
    chk("idle_result", 32'(obs_res()), 32'(prev_res));
  endtask

  task automatic run_neuron(input int th, input int hold, input bit noise);
    do_start(th);
    send_beats(noise);
    exp_q.push_back(model(th));
    finish_result(hold, noise);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_ctl", 32'(obs_ctl()), 32'(6'b000000));
    chk("rst_result", 32'(obs_res()), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    prev_res = '0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    thresh    = '0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    prev_res  = '0;
    @(negedge clk);
    chk("por_ctl", 32'(obs_ctl()), 32'(6'b000000));
    chk("por_result", 32'(obs_res()), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 01, 11, 00(last) with thresh 3, then thresh 4 and a 5-cycle stall
    load({2'b00, 2'b00, 2'b11, 2'b01}, 4'b0100);
    run_neuron(3, 0, 1'b0);
    run_neuron(4, 5, 1'b0);

    // forced end after MAXB beats, then the same sum ended by in_last with thresh 0
    load(8'hFF, 4'b0000);
    run_neuron(9, 1, 1'b0);
    load(8'hFF, 4'b1000);
    run_neuron(0, 0, 1'b0);

    // reset after two accepted beats, then a fresh neuron
    do_start(5);
    in_valid = 1'b1; in_op = 2'b01; in_last = 1'b0;
    @(negedge clk);
    in_op = 2'b11;
    @(negedge clk);
    in_valid = 1'b0;
    pulse_reset();
    load({2'b00, 2'b00, 2'b00, 2'b10}, 4'b0001);
    run_neuron(2, 0, 1'b0);

    // reset while a result is pending
    load(8'h55, 4'b0010);
    do_start(1);
    send_beats(1'b0);
    chk("pend_ctl", 32'(obs_ctl()), 32'(6'b101101));
    pulse_reset();

    // spurious starts and input gaps
    load({2'b10, 2'b11, 2'b01, 2'b11}, 4'b0100);
    run_neuron(2, 2, 1'b1);

    repeat (30) begin
      for (int k = 0; k < MAXB; k++) begin
        beat_op[k]   = 2'($urandom);
        beat_last[k] = ($urandom_range(0, 3) == 0);
      end
      run_neuron($urandom_range(0, 9), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
